// File: rtl/xor_fold_hash_unit_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg
//   Shared definitions for the XOR-fold hash unit:
//     - state_e     : FSM states of the hash unit (IDLE, FOLD, DONE)
//     - MODE_XOR    : plain XOR folding of chunks
//     - MODE_ROTXOR : rotate-left-by-one of the accumulator before each XOR
//     - rotl()      : rotate a value left within the low 'w' bits of a
//                     ROTL_MAX_W-bit container (bits at or above w stay zero)
// ---------------------------------------------------------------------------
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_XOR    = 1'b0;
  localparam logic MODE_ROTXOR = 1'b1;

  // Widest hash/chunk the rotate helper can handle.
  localparam int ROTL_MAX_W = 64;

  // Rotate x left by amt positions inside a w-bit field. Called with
  // constant amt and w, so this reduces to pure wiring.
  function automatic logic [ROTL_MAX_W-1:0] rotl(
    input logic [ROTL_MAX_W-1:0] x,
    input int                    amt,
    input int                    w
  );
    logic [ROTL_MAX_W-1:0] r;
    r = '0;
    if (w > 0) begin
      for (int i = 0; i < ROTL_MAX_W; i++) begin
        if (i < w) begin
          r[(i + amt) % w] = x[i];
        end
      end
    end
    return r;
  endfunction

endpackage : hash_pkg

// File: rtl/xor_fold_hash_unit_step.sv
// ---------------------------------------------------------------------------
// xor_fold_step
//   Purely combinational fold of CHUNKS_PER_CYC chunks into an accumulator.
//   The chunk in the most significant position of 'chunks' is folded first.
//   Each step:  mode = MODE_XOR    : acc' = acc ^ chunk
//               mode = MODE_ROTXOR : acc' = rotl(acc,1) ^ chunk
// Ports
//   acc_in   in   HASH_W                  accumulator before this cycle
//   chunks   in   CHUNKS_PER_CYC*HASH_W   chunks for this cycle, MS first
//   mode     in   1                       fold mode
//   acc_out  out  HASH_W                  accumulator after all steps
// ---------------------------------------------------------------------------
module xor_fold_step
  import hash_pkg::*;
#(
  parameter int HASH_W         = 8,
  parameter int CHUNKS_PER_CYC = 8
) (
  input  logic [HASH_W-1:0]                acc_in,
  input  logic [CHUNKS_PER_CYC*HASH_W-1:0] chunks,
  input  logic                             mode,
  output logic [HASH_W-1:0]                acc_out
);

  localparam int SLICE_W = CHUNKS_PER_CYC * HASH_W;

  if (HASH_W > ROTL_MAX_W) begin : g_bad_hash_w
    $error("xor_fold_step: HASH_W exceeds ROTL_MAX_W");
  end

  // stage[0] is the incoming accumulator, stage[gi+1] the value after
  // folding chunk gi.
  logic [HASH_W-1:0] stage [CHUNKS_PER_CYC+1];

  assign stage[0] = acc_in;

  for (genvar gi = 0; gi < CHUNKS_PER_CYC; gi++) begin : g_step
    logic [HASH_W-1:0]     chunk;
    logic [ROTL_MAX_W-1:0] rot_wide;
    logic [HASH_W-1:0]     rot;
    logic                  unused_rot_hi;

    assign chunk    = chunks[SLICE_W-1-gi*HASH_W -: HASH_W];
    assign rot_wide = rotl(ROTL_MAX_W'(stage[gi]), 1, HASH_W);
    assign rot      = rot_wide[HASH_W-1:0];
    // Bits above HASH_W are always zero; reduce them to keep them referenced.
    assign unused_rot_hi = ^rot_wide;

    assign stage[gi+1] = ((mode == MODE_ROTXOR) ? rot : stage[gi]) ^ chunk;
  end

  assign acc_out = stage[CHUNKS_PER_CYC];

endmodule : xor_fold_step

// File: rtl/xor_fold_hash_unit.sv
// ---------------------------------------------------------------------------
// xor_fold_hash_unit
//   Multi-cycle XOR-fold hash of one LINE_W-bit cache line into a HASH_W-bit
//   tag. The line is split into N_CHUNKS = LINE_W/HASH_W chunks (chunk 0 is
//   the most significant and folded first); CHUNKS_PER_CYC chunks are folded
//   per clock, so a line takes FOLD_CYC = N_CHUNKS/CHUNKS_PER_CYC cycles.
//   Plain XOR or rotate-XOR mode is latched with the line.
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       line_in / mode_in valid
//   in_ready   out  1       unit can accept a line (IDLE)
//   line_in    in   LINE_W  cache line to hash
//   mode_in    in   1       0 = plain XOR, 1 = rotate-XOR
//   out_valid  out  1       hash_out valid
//   out_ready  in   1       consumer accepts hash_out
//   hash_out   out  HASH_W  resulting hash
// Timing: a line accepted at edge E shows out_valid at edge E+FOLD_CYC; the
// result is held until out_ready, after which the unit returns to IDLE.
// ---------------------------------------------------------------------------
module xor_fold_hash_unit
  import hash_pkg::*;
#(
  parameter int LINE_W         = 512,
  parameter int HASH_W         = 8,
  parameter int CHUNKS_PER_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] line_in,
  input  logic              mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HASH_W-1:0] hash_out
);

  localparam int N_CHUNKS = LINE_W / HASH_W;
  localparam int FOLD_CYC = N_CHUNKS / CHUNKS_PER_CYC;
  localparam int SLICE_W  = CHUNKS_PER_CYC * HASH_W;
  localparam int CNT_W    = (FOLD_CYC > 1) ? $clog2(FOLD_CYC) : 1;
  localparam int N_SLOTS  = 2 ** CNT_W;

  if ((LINE_W % HASH_W) != 0) begin : g_bad_line_w
    $error("xor_fold_hash_unit: LINE_W must be a multiple of HASH_W");
  end
  if ((N_CHUNKS % CHUNKS_PER_CYC) != 0) begin : g_bad_cpc
    $error("xor_fold_hash_unit: N_CHUNKS must be a multiple of CHUNKS_PER_CYC");
  end

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [LINE_W-1:0] line_q,      line_d;
  logic              mode_q,      mode_d;
  logic [HASH_W-1:0] acc_q,       acc_d;
  logic [HASH_W-1:0] hash_q,      hash_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;

  // ------------------------------------------------------------------
  // Chunk-slice mux: slot gi holds the chunks folded in cycle gi. The
  // table is padded to a power of two so cnt_q indexes it directly; the
  // padding slots are never selected because cnt_q stops at FOLD_CYC-1.
  // ------------------------------------------------------------------
  logic [SLICE_W-1:0] slices [N_SLOTS];
  logic [SLICE_W-1:0] cur_slice;
  logic [HASH_W-1:0]  step_acc;

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slice
    if (gi < FOLD_CYC) begin : g_used
      assign slices[gi] = line_q[LINE_W-1-gi*SLICE_W -: SLICE_W];
    end else begin : g_pad
      assign slices[gi] = '0;
    end
  end

  assign cur_slice = slices[cnt_q];

  xor_fold_step #(
    .HASH_W         (HASH_W),
    .CHUNKS_PER_CYC (CHUNKS_PER_CYC)
  ) u_step (
    .acc_in  (acc_q),
    .chunks  (cur_slice),
    .mode    (mode_q),
    .acc_out (step_acc)
  );

  // ------------------------------------------------------------------
  // Register process
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      mode_q      <= MODE_XOR;
      acc_q       <= '0;
      hash_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      hash_q      <= hash_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state / output process
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    hash_d      = hash_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          line_d  = line_in;
          mode_d  = mode_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FOLD;
        end
      end

      FOLD: begin
        acc_d = step_acc;
        if (cnt_q == CNT_W'(FOLD_CYC - 1)) begin
          // Last slice: publish the hash; cnt_q is left at its final value.
          hash_d      = step_acc;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign hash_out  = hash_q;

endmodule : xor_fold_hash_unit

// File: tb/tb_xor_fold_hash_unit.sv
// ---------------------------------------------------------------------------
// tb_xor_fold_hash_unit
//   Directed and random checks of xor_fold_hash_unit with default parameters.
//   The reference hash is the closed form of the fold: in XOR mode the XOR of
//   all chunks; in rotate mode chunk k contributes rotl(chunk_k, (N-1-k)%8).
// ---------------------------------------------------------------------------
module tb_xor_fold_hash_unit;

  localparam int LINE_W   = 512;
  localparam int HASH_W   = 8;
  localparam int CPC      = 8;
  localparam int N_CHUNKS = LINE_W / HASH_W;
  localparam int FOLD_CYC = N_CHUNKS / CPC;
  localparam int BOUND    = 100;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [LINE_W-1:0] line_in;
  logic              mode_in;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] hash_out;

  int total = 0;
  int bad   = 0;

  xor_fold_hash_unit #(
    .LINE_W         (LINE_W),
    .HASH_W         (HASH_W),
    .CHUNKS_PER_CYC (CPC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .line_in   (line_in),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash_out  (hash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rot8(input logic [7:0] c, input int r);
    logic [15:0] t;
    t = {c, c} << r;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ref_hash(input logic [LINE_W-1:0] line, input logic mode);
    logic [7:0] h;
    logic [7:0] c;
    h = 8'h00;
    for (int k = 0; k < N_CHUNKS; k++) begin
      c = line[LINE_W-1-k*HASH_W -: HASH_W];
      h = h ^ (mode ? rot8(c, (N_CHUNKS - 1 - k) % 8) : c);
    end
    return h;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one line, scramble the inputs after acceptance, check latency and
  // hash, then drain the result.
  task automatic run_line(input logic [LINE_W-1:0] line, input logic mode, input string tag);
    int n;
    int cyc;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1;
    line_in  = line;
    mode_in  = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    line_in  = ~line;
    mode_in  = ~mode;
    cyc = 0;
    while (!out_valid && cyc < BOUND) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(FOLD_CYC));
    check(tag, 64'(hash_out), 64'(ref_hash(line, mode)));
    $display("line %s mode=%0d hash=0x%02h latency=%0d", tag, mode, hash_out, cyc);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    logic [LINE_W-1:0] lb;
    logic [7:0]        h0;
    int                cyc;
    bit                seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    line_in   = '0;
    mode_in   = 1'b0;
    #2;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_hash",      64'(hash_out),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all zero
    run_line('0, 1'b0, "zero_xor");

    // 2: only chunk 0 set
    l = '0;
    l[LINE_W-1 -: 8] = 8'hA5;
    run_line(l, 1'b0, "a5_xor");
    run_line(l, 1'b1, "a5_rot");
    check("a5_rot_const", 64'(hash_out), 64'hD2);

    // 3: all ones, even chunk count cancels in both modes
    run_line('1, 1'b0, "ff_xor");
    check("ff_xor_const", 64'(hash_out), 64'h00);
    run_line('1, 1'b1, "ff_rot");
    check("ff_rot_const", 64'(hash_out), 64'h00);

    // 4: chunk k = k
    for (int k = 0; k < N_CHUNKS; k++) l[LINE_W-1-k*HASH_W -: HASH_W] = 8'(k);
    run_line(l, 1'b0, "ramp_xor");
    check("ramp_xor_const", 64'(hash_out), 64'h00);
    run_line(l, 1'b1, "ramp_rot");

    // random lines in both modes
    for (int i = 0; i < 1000; i++) begin
      run_line(rand_line(), 1'b0, "rand_xor");
      run_line(rand_line(), 1'b1, "rand_rot");
    end

    // 5: back-pressure with a second line held on the input
    l  = rand_line();
    lb = rand_line();
    in_valid = 1'b1; line_in = l; mode_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < BOUND) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp_latency", 64'(cyc), 64'(FOLD_CYC));
    h0 = ref_hash(l, 1'b1);
    in_valid = 1'b1; line_in = lb; mode_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hash",      64'(hash_out),  64'(h0));
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    $display("backpressure hold hash=0x%02h", hash_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    check("bp_accept_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < BOUND) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp2_latency", 64'(cyc), 64'(FOLD_CYC));
    check("bp2_hash", 64'(hash_out), 64'(ref_hash(lb, 1'b0)));
    $display("backpressure second line hash=0x%02h", hash_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // 6: reset in the middle of FOLD
    l = rand_line();
    in_valid = 1'b1; line_in = l; mode_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_hash",      64'(hash_out),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 64'(seen), 64'd0);
    $display("mid-fold reset: spurious output seen=%0d", seen);
    run_line(rand_line(), 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_xor_fold_hash_unit
